pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage pipeline. Sits beside the forwarding unit.
- Takes the ID-stage source selects and the EX/MEM-stage destination info the forwarding unit cannot resolve: load-use, cache misses, taken branches and halt.
- Drives enable/flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Holds a small FSM for multi-cycle data-cache waits and sticky halt.

---
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, dcache wait, branch redirect, sticky halt.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] rsel1_o1,
    input  logic [REG_W-1:0] rsel2_o1,
    input  logic             uses_rt_o1,
    input  logic [REG_W-1:0] wsel_o2,
    input  logic             wen_o2,
    input  logic             dren_o2,
    input  logic             dmem_req_o3,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             branch_taken_o3,
    input  logic             halt_o4,
    output logic             pc_en,
    output logic             pc_sel_target,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DWAIT  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       load_use;

    // $0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = dren_o2 && wen_o2 && (wsel_o2 != '0) &&
                      ((wsel_o2 == rsel1_o1) || (uses_rt_o1 && (wsel_o2 == rsel2_o1)));

    always_comb begin
        pc_en         = 1'b0;
        pc_sel_target = 1'b0;
        ifid_en       = 1'b0;
        idex_en       = 1'b0;
        exmem_en      = 1'b0;
        memwb_en      = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        halt          = (state == HALTED);
        state_next    = state;

        if (RST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            state_next  = RUN;
        end else if (state != HALTED) begin
            state_next = RUN;
            // DWAIT with dhit falls through to the RUN priorities minus the miss rule
            if (state == DWAIT && !dhit) begin
                memwb_flush = 1'b1;
                state_next  = DWAIT;
            end else if (halt_o4) begin
                state_next = HALTED;
            end else if (state == RUN && dmem_req_o3 && !dhit) begin
                memwb_flush = 1'b1;
                state_next  = DWAIT;
            end else if (branch_taken_o3) begin
                pc_en         = 1'b1;
                pc_sel_target = 1'b1;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
                exmem_flush   = 1'b1;
                memwb_en      = 1'b1;
            end else if (load_use) begin
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (!ihit) begin
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // pc_sel_target is asserted exactly on branch-redirect cycles
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (state != HALTED && !pc_en && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (pc_sel_target && flush_events != '1) begin
                flush_events <= flush_events + CNT_ONE;
            end
        end
    end
`endif

endmodule
